filter_frame_ctrl: RTL and testbench

Frame-level sequencer for the 3×3 line-buffer filter unit. It accepts one frame of 9-bit pixels over a ready/valid stream, drives the free-running filter with a gap-free pixel stream, and injects the zero-padding flush needed to emit the last row. It tags each filter output with its centre pixel's position, flags border windows, and emits exactly W×H output pixels per frame. It sits between the pixel source/DMA and the filter unit, which it owns through `flt_rst`, `flt_data_in` and `flt_width`.

---
 rtl/filter_pkg.sv | 25 ++
 rtl/filter_pos_counter.sv | 36 +++
 rtl/filter_frame_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_filter_frame_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types and constants for the 3x3 line-buffer filter unit and its frame sequencer.
package filter_pkg;

   localparam int PIX_W     = 9;
   localparam int MAX_WIDTH = 1024;
   localparam int CNT_W     = 16;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } frame_state_t;

   typedef struct packed {
      logic valid;
      logic border;
      logic sof;
      logic eol;
   } out_tag_t;

endpackage

// File: rtl/filter_pos_counter.sv
// Column/row position counter for a W x H raster; both coordinates wrap to 0 after their last value.
module filter_pos_counter
   import filter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] height,
   output logic [CNT_W-1:0] col,
   output logic [CNT_W-1:0] row,
   output logic             last_col,
   output logic             last_row
);

   assign last_col = (col == width - CNT_ONE);
   assign last_row = (row == height - CNT_ONE);

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + CNT_ONE;
         end else begin
            col <= col + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for the 3x3 filter: feeds one frame plus a zero flush, then tags each
// filter result with its centre position, masks borders and emits exactly W x H outputs.
module filter_frame_ctrl
   import filter_pkg::*;
#(
   parameter int OP_LATENCY = 2,
   parameter int MAX_WIDTH  = filter_pkg::MAX_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      cfg_width,
   input  logic [15:0]      cfg_height,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic             underrun,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_data,
   output logic             in_ready,
   output logic             flt_rst,
   output logic [PIX_W-1:0] flt_data_in,
   output logic [31:0]      flt_width,
   input  logic [PIX_W-1:0] flt_data_out,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_data,
   output logic             out_border,
   output logic             out_sof,
   output logic             out_eol
);

   localparam logic [CNT_W-1:0] MIN_DIM    = 3;
   localparam logic [CNT_W-1:0] MAX_W      = CNT_W'(MAX_WIDTH);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(OP_LATENCY);

   frame_state_t state;
   logic [CNT_W-1:0] width_q;
   logic [CNT_W-1:0] height_q;
   logic [CNT_W-1:0] phase_cnt;
   logic             centre_live;

   logic             cfg_ok;
   logic             accept;
   logic             issue;
   logic             centre_en;

   logic [CNT_W-1:0] in_col;
   logic [CNT_W-1:0] in_row;
   logic             in_last_col;
   logic             in_last_row;
   logic [CNT_W-1:0] c_col;
   logic [CNT_W-1:0] c_row;
   logic             c_last_col;
   logic             c_last_row;

   out_tag_t                  tag_in;
   out_tag_t [OP_LATENCY:0]   tag_pipe;
   out_tag_t                  tag_out;

   assign cfg_ok    = (cfg_width >= MIN_DIM) && (cfg_width <= MAX_W) && (cfg_height >= MIN_DIM);
   assign accept    = (state == S_IDLE) && start && cfg_ok;
   assign issue     = (state == S_RUN) || (state == S_FLUSH);
   // Centres start one issue after input position (row 1, col 0), i.e. at n = W+1.
   assign centre_en = issue && centre_live;
   assign flt_width = {16'b0, width_q};

   filter_pos_counter u_in_pos (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .en       (issue),
      .width    (width_q),
      .height   (height_q),
      .col      (in_col),
      .row      (in_row),
      .last_col (in_last_col),
      .last_row (in_last_row)
   );

   filter_pos_counter u_centre_pos (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .en       (centre_en),
      .width    (width_q),
      .height   (height_q),
      .col      (c_col),
      .row      (c_row),
      .last_col (c_last_col),
      .last_row (c_last_row)
   );

   // NOTE: every signal written in always_comb gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      flt_data_in = '0;
      if (state == S_RUN && in_valid) flt_data_in = in_data;
   end

   always_comb begin
      tag_in        = '0;
      tag_in.valid  = centre_en;
      tag_in.border = centre_en && (c_col == '0 || c_last_col || c_row == '0 || c_last_row);
      tag_in.sof    = centre_en && (c_col == '0) && (c_row == '0);
      tag_in.eol    = centre_en && c_last_col;
   end

   // NOTE: the tag delay line is reset because its valid bits drive out_valid directly;
   // stale tags after a mid-frame reset would emit phantom outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_pipe <= '0;
      end else begin
         tag_pipe[0] <= tag_in;
         for (int i = 1; i <= OP_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   assign tag_out    = tag_pipe[OP_LATENCY];
   assign out_valid  = tag_out.valid;
   assign out_border = tag_out.valid && tag_out.border;
   assign out_sof    = tag_out.valid && tag_out.sof;
   assign out_eol    = tag_out.valid && tag_out.eol;
   assign out_data   = (tag_out.valid && !tag_out.border) ? flt_data_out : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         width_q     <= '0;
         height_q    <= '0;
         phase_cnt   <= '0;
         centre_live <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cfg_err     <= 1'b0;
         underrun    <= 1'b0;
         in_ready    <= 1'b0;
         flt_rst     <= 1'b1;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (issue && in_row == CNT_ONE && in_col == '0) centre_live <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     width_q     <= cfg_width;
                     height_q    <= cfg_height;
                     phase_cnt   <= '0;
                     centre_live <= 1'b0;
                     underrun    <= 1'b0;
                     busy        <= 1'b1;
                     in_ready    <= 1'b1;
                     flt_rst     <= 1'b0;
                     state       <= S_RUN;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (!in_valid) underrun <= 1'b1;
               if (in_last_col && in_last_row) begin
                  in_ready <= 1'b0;
                  state    <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               // The input counter wrapped to (0,0) at the frame end; W+1 flush issues end at (1,0).
               if (in_row == CNT_ONE) begin
                  phase_cnt <= '0;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (phase_cnt == DRAIN_LAST) begin
                  done    <= 1'b1;
                  flt_rst <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  phase_cnt <= phase_cnt + CNT_ONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Scoreboard bench for filter_frame_ctrl; a delay-line stand-in returns each issued pixel
// exactly at its centre's output slot, so interior outputs equal the centre pixel.
module tb_filter_frame_ctrl;
   import filter_pkg::*;

   localparam int OPL = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] cfg_width = '0;
   logic [15:0] cfg_height = '0;
   logic        busy, done, cfg_err, underrun;
   logic        in_valid = 1'b0;
   logic [8:0]  in_data = '0;
   logic        in_ready;
   logic        flt_rst;
   logic [8:0]  flt_data_in;
   logic [31:0] flt_width;
   logic [8:0]  flt_data_out;
   logic        out_valid, out_border, out_sof, out_eol;
   logic [8:0]  out_data;

   typedef struct {
      int cyc;
      int data;
      int border;
      int sof;
      int eol;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   cur_w = 4;
   logic [8:0] ring [0:4095];

   filter_frame_ctrl #(.OP_LATENCY(OPL), .MAX_WIDTH(1024)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cfg_width    (cfg_width),
      .cfg_height   (cfg_height),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err),
      .underrun     (underrun),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .flt_rst      (flt_rst),
      .flt_data_in  (flt_data_in),
      .flt_width    (flt_width),
      .flt_data_out (flt_data_out),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_border   (out_border),
      .out_sof      (out_sof),
      .out_eol      (out_eol)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ring[12'(cyc)] <= flt_data_in;
      cyc <= cyc + 1;
   end

   always_comb begin
      flt_data_out = ring[12'(cyc - (cur_w + 2 + OPL))];
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [8:0] pix(input int base, input int k);
      return 9'((base + k) % 512);
   endfunction

   // Monitor: pops one expectation per out_valid and per done.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_cycle", cyc, e.cyc);
            check("out_data", int'(out_data), e.data);
            check("out_border", int'(out_border), e.border);
            check("out_sof", int'(out_sof), e.sof);
            check("out_eol", int'(out_eol), e.eol);
         end
      end else begin
         check("idle_outputs_zero", int'({out_data, out_sof, out_eol, out_border}), 0);
      end
      if (done === 1'b1) begin
         if (done_q.size() == 0) check("unexpected_done", 1, 0);
         else check("done_cycle", cyc, done_q.pop_front());
      end
   end

   task automatic run_frame(input int w, input int h, input int drop, input int base,
                            output int s);
      @(negedge clk);
      cur_w      = w;
      cfg_width  = 16'(w);
      cfg_height = 16'(h);
      start      = 1'b1;
      s          = cyc;
      for (int k = 0; k < w * h; k++) begin
         exp_t e;
         int col, row;
         col      = k % w;
         row      = k / w;
         e.cyc    = s + 1 + k + w + 2 + OPL;
         e.border = (col == 0 || col == w - 1 || row == 0 || row == h - 1) ? 1 : 0;
         e.data   = (e.border == 1 || k == drop) ? 0 : int'(pix(base, k));
         e.sof    = (k == 0) ? 1 : 0;
         e.eol    = (col == w - 1) ? 1 : 0;
         exp_q.push_back(e);
      end
      done_q.push_back(s + w * h + w + OPL + 3);
      @(negedge clk);
      start = 1'b0;
      check("run_busy", int'(busy), 1);
      check("run_flt_rst", int'(flt_rst), 0);
      check("run_in_ready", int'(in_ready), 1);
      check("run_underrun_clear", int'(underrun), 0);
      check("flt_width", int'(flt_width), w);
      for (int k = 0; k < w * h; k++) begin
         if (k > 0) @(negedge clk);
         in_valid = (k != drop);
         in_data  = pix(base, k);
         if (k == drop) check("underrun_before_drop", int'(underrun), 0);
         if (drop >= 0 && k == drop + 1) check("underrun_set", int'(underrun), 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      check("flush_in_ready", int'(in_ready), 0);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", int'(done === 1'b1), 1);
   endtask

   task automatic post_frame();
      check("outputs_drained", exp_q.size(), 0);
      @(negedge clk);
      check("post_busy", int'(busy), 0);
      check("post_flt_rst", int'(flt_rst), 1);
      check("post_done_low", int'(done), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, s1, s2, r;
      int bad_w [3] = '{2, 4, 1025};
      int bad_h [3] = '{4, 2, 4};

      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_flt_rst", int'(flt_rst), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_flt_width", int'(flt_width), 0);
      check("rst_flt_data_in", int'(flt_data_in), 0);
      rst = 1'b0;

      // Nominal 4x3 frame with pixels 1..12.
      run_frame(4, 3, -1, 1, s);
      wait_done(200);
      post_frame();

      // Rejected configurations.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cfg_width  = 16'(bad_w[i]);
         cfg_height = 16'(bad_h[i]);
         start      = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("cfg_err_pulse", int'(cfg_err), 1);
         check("cfg_err_busy", int'(busy), 0);
         check("cfg_err_flt_rst", int'(flt_rst), 1);
         @(negedge clk);
         check("cfg_err_one_cycle", int'(cfg_err), 0);
         check("cfg_err_still_idle", int'(busy), 0);
      end

      // Underrun on pixel 6 (k=5).
      run_frame(4, 3, 5, 20, s);
      wait_done(200);
      check("underrun_sticky", int'(underrun), 1);
      post_frame();
      check("underrun_held_idle", int'(underrun), 1);

      // Back-to-back 8x4 frames, second start the cycle after done.
      run_frame(8, 4, -1, 40, s1);
      wait_done(300);
      run_frame(8, 4, -1, 90, s2);
      check("b2b_start_gap", s2 - s1, 8 * 4 + 8 + OPL + 4);
      wait_done(300);
      post_frame();

      // Reset during FLUSH.
      run_frame(4, 3, -1, 60, s);
      @(negedge clk);
      rst = 1'b1;
      r   = cyc + 1;
      while (exp_q.size() > 0 && exp_q[$].cyc >= r) void'(exp_q.pop_back());
      done_q.delete();
      @(negedge clk);
      check("midrst_busy", int'(busy), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_flt_rst", int'(flt_rst), 1);
      check("midrst_in_ready", int'(in_ready), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst_no_leftover", exp_q.size(), 0);
      run_frame(4, 3, -1, 100, s);
      wait_done(200);
      post_frame();

      // Maximum width.
      run_frame(1024, 3, -1, 7, s);
      wait_done(5000);
      post_frame();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
